// File: rtl/vga_out_pkg.sv
// Shared types and constants for the VGA output stage: test modes, timing bus
// layout and the colour-bar table.
package vga_out_pkg;

  typedef enum logic [1:0] {
    TM_PASS  = 2'b00,
    TM_BARS  = 2'b01,
    TM_GRID  = 2'b10,
    TM_WHITE = 2'b11
  } test_mode_e;

  localparam int unsigned COLOR_W_DEF = 4;
  localparam int unsigned COORD_W     = 12;
  localparam int unsigned TIMING_W    = 3 + 2 * COORD_W;

  typedef struct packed {
    logic               video_on;
    logic               hs;
    logic               vs;
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
  } timing_t;

  // Entry i holds {R,G,B} on/off bits for bar i.
  localparam logic [7:0][2:0] BAR_RGB = {3'd7, 3'd6, 3'd5, 3'd4,
                                         3'd3, 3'd2, 3'd1, 3'd0};

  // Bar index comes from column bits [9:7]; anything past 1023 is the last bar.
  function automatic logic [2:0] bar_rgb(input logic [COORD_W-1:0] col);
    logic [2:0] idx;
    idx = (col[COORD_W-1:10] != '0) ? 3'd7 : col[9:7];
    return BAR_RGB[idx];
  endfunction

endpackage

// File: rtl/sig_delay_line.sv
// Fixed-latency shift register with asynchronous clear; q is d delayed DEPTH cycles.
module sig_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_out_stage.sv
// Final VGA output stage: realigns timing with the pixel pipeline, applies
// test patterns, and produces registered colour/sync plus frame/line markers.
module vga_out_stage
  import vga_out_pkg::*;
#(
  parameter int unsigned PIPE_DLY = 2,
  parameter int unsigned COLOR_W  = COLOR_W_DEF
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               video_on,
  input  logic               horiz_sync,
  input  logic               vert_sync,
  input  logic [11:0]        pixel_row,
  input  logic [11:0]        pixel_column,
  input  logic [COLOR_W-1:0] rgb_r,
  input  logic [COLOR_W-1:0] rgb_g,
  input  logic [COLOR_W-1:0] rgb_b,
  input  logic [1:0]         test_mode,
  output logic [COLOR_W-1:0] VGA_R,
  output logic [COLOR_W-1:0] VGA_G,
  output logic [COLOR_W-1:0] VGA_B,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               frame_start,
  output logic               line_start,
  output logic [15:0]        frame_cnt
);

  timing_t tin_c;
  timing_t dly_c;

  assign tin_c = {video_on, horiz_sync, vert_sync, pixel_row, pixel_column};

  sig_delay_line #(
    .WIDTH(TIMING_W),
    .DEPTH(PIPE_DLY)
  ) u_timing_dly (
    .clk (clk),
    .rstn(rstn),
    .d   (tin_c),
    .q   (dly_c)
  );

  logic               von_prev_q, von_prev_d;
  test_mode_e         mode_q, mode_d;
  logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic               hs_q, hs_d, vs_q, vs_d;
  logic               fs_q, fs_d, ls_q, ls_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;

  logic               ls_c, fs_c, grid_c;
  logic [2:0]         bar_c;
  test_mode_e         mode_c;

  // Pattern generation; a new mode applies from the very pixel that starts the frame.
  always_comb begin
    ls_c        = dly_c.video_on & ~von_prev_q;
    fs_c        = ls_c & (dly_c.row == '0);
    mode_c      = fs_c ? test_mode_e'(test_mode) : mode_q;
    bar_c       = bar_rgb(dly_c.col);
    grid_c      = (dly_c.col[4:0] == 5'd0) || (dly_c.row[4:0] == 5'd0);

    von_prev_d  = dly_c.video_on;
    mode_d      = mode_c;
    hs_d        = dly_c.hs;
    vs_d        = dly_c.vs;
    ls_d        = ls_c;
    fs_d        = fs_c;
    frame_cnt_d = frame_cnt_q + 16'(fs_c);
    r_d         = '0;
    g_d         = '0;
    b_d         = '0;

    if (dly_c.video_on) begin
      case (mode_c)
        TM_PASS: begin
          r_d = rgb_r;
          g_d = rgb_g;
          b_d = rgb_b;
        end
        TM_BARS: begin
          r_d = {COLOR_W{bar_c[2]}};
          g_d = {COLOR_W{bar_c[1]}};
          b_d = {COLOR_W{bar_c[0]}};
        end
        TM_GRID: begin
          r_d = {COLOR_W{grid_c}};
          g_d = {COLOR_W{grid_c}};
          b_d = {COLOR_W{grid_c}};
        end
        TM_WHITE: begin
          r_d = '1;
          g_d = '1;
          b_d = '1;
        end
        default: begin
          r_d = '0;
          g_d = '0;
          b_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      von_prev_q  <= 1'b0;
      mode_q      <= TM_PASS;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      fs_q        <= 1'b0;
      ls_q        <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      von_prev_q  <= von_prev_d;
      mode_q      <= mode_d;
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      fs_q        <= fs_d;
      ls_q        <= ls_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign frame_start = fs_q;
  assign line_start  = ls_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_out_stage.sv
// Randomized bench for vga_out_stage: a scaled-down timing generator drives the
// DUT and a cycle-history reference model predicts every output each cycle.
module tb_vga_out_stage;

  localparam int unsigned PIPE_DLY = 2;
  localparam int unsigned CW       = 4;
  localparam int H_TOT = 48, H_ACT = 40, V_TOT = 12, V_ACT = 10;
  localparam int COL_STEP = 28, ROW_STEP = 16;
  localparam int FRAME_CYC = H_TOT * V_TOT;
  localparam int TOTAL = 15 * FRAME_CYC;

  logic          clk, rstn;
  logic          video_on, horiz_sync, vert_sync;
  logic [11:0]   pixel_row, pixel_column;
  logic [CW-1:0] rgb_r, rgb_g, rgb_b;
  logic [1:0]    test_mode;
  logic [CW-1:0] VGA_R, VGA_G, VGA_B;
  logic          VGA_HS, VGA_VS, frame_start, line_start;
  logic [15:0]   frame_cnt;

  vga_out_stage #(.PIPE_DLY(PIPE_DLY), .COLOR_W(CW)) dut (
    .clk(clk), .rstn(rstn), .video_on(video_on), .horiz_sync(horiz_sync),
    .vert_sync(vert_sync), .pixel_row(pixel_row), .pixel_column(pixel_column),
    .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b), .test_mode(test_mode),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .frame_start(frame_start), .line_start(line_start), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One recorded input interval; rst marks intervals the DUT spent in reset.
  typedef struct {
    bit rst; bit von; bit hs; bit vs;
    int row; int col; int r; int g; int b; int tm;
  } smp_t;

  smp_t hist [16];
  int   checks, errors;
  int   m, h, v, frame;
  int   mode_m, cnt_m, lines, rst_at;
  bit   track_ok;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, m);
    end
  endtask

  function automatic smp_t blank_smp();
    smp_t s;
    s.rst = 1'b1; s.von = 1'b0; s.hs = 1'b0; s.vs = 1'b0;
    s.row = 0; s.col = 0; s.r = 0; s.g = 0; s.b = 0; s.tm = 0;
    return s;
  endfunction

  // Expected {R,G,B} from the mode rules, using delayed timing t and current rgb c.
  function automatic logic [11:0] exp_rgb(input int mode, input smp_t t, input smp_t c);
    logic [2:0] idx;
    if (!t.von) return 12'h000;
    case (mode)
      0: return {4'(c.r), 4'(c.g), 4'(c.b)};
      1: begin
        idx = (t.col >= 1024) ? 3'd7 : 3'(t.col / 128);
        return {(idx[2] ? 4'hF : 4'h0), (idx[1] ? 4'hF : 4'h0), (idx[0] ? 4'hF : 4'h0)};
      end
      2: return ((t.col % 32 == 0) || (t.row % 32 == 0)) ? 12'hFFF : 12'h000;
      default: return 12'hFFF;
    endcase
  endfunction

  task automatic drive_and_record();
    smp_t s;
    video_on     = (h < H_ACT) && (v < V_ACT);
    horiz_sync   = !(h >= 42 && h < 46);
    vert_sync    = !(v == V_ACT + 1);
    pixel_column = 12'(h * COL_STEP);
    pixel_row    = 12'(v * ROW_STEP);
    rgb_r        = 4'($urandom_range(0, 15));
    rgb_g        = 4'($urandom_range(0, 15));
    rgb_b        = 4'($urandom_range(0, 15));
    if (rstn) begin
      s.rst = 1'b0; s.von = video_on; s.hs = horiz_sync; s.vs = vert_sync;
      s.row = int'(pixel_row); s.col = int'(pixel_column);
      s.r = int'(rgb_r); s.g = int'(rgb_g); s.b = int'(rgb_b); s.tm = int'(test_mode);
    end else begin
      s = blank_smp();
    end
    hist[m & 15] = s;
    h++;
    if (h == H_TOT) begin
      h = 0;
      v++;
      if (v == V_TOT) begin
        v = 0;
        frame++;
      end
    end
  endtask

  task automatic check_cycle();
    smp_t t, tp, c;
    bit   e_ls, e_fs, e_hs, e_vs;
    int   eff;
    logic [11:0] e_rgb;
    e_ls = 1'b0; e_fs = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_rgb = 12'h000;
    c  = hist[(m - 1) & 15];
    t  = hist[(m - int'(PIPE_DLY) - 1) & 15];
    tp = hist[(m - int'(PIPE_DLY) - 2) & 15];
    if (!rstn || c.rst) begin
      mode_m = 0; cnt_m = 0; track_ok = 1'b0; lines = 0;
    end else begin
      e_ls = t.von && !tp.von;
      e_fs = e_ls && (t.row == 0);
      if (e_fs) begin
        cnt_m  = (cnt_m + 1) & 16'hFFFF;
        mode_m = c.tm;
      end
      eff   = mode_m;
      e_hs  = t.hs;
      e_vs  = t.vs;
      e_rgb = exp_rgb(eff, t, c);
    end
    check_eq("vga_r", 32'(VGA_R), 32'(e_rgb[11:8]));
    check_eq("vga_g", 32'(VGA_G), 32'(e_rgb[7:4]));
    check_eq("vga_b", 32'(VGA_B), 32'(e_rgb[3:0]));
    check_eq("vga_hs", 32'(VGA_HS), 32'(e_hs));
    check_eq("vga_vs", 32'(VGA_VS), 32'(e_vs));
    check_eq("line_start", 32'(line_start), 32'(e_ls));
    check_eq("frame_start", 32'(frame_start), 32'(e_fs));
    check_eq("frame_cnt", 32'(frame_cnt), 32'(cnt_m));
    // Line pulses counted between observed frame starts must equal the active line count.
    if (rstn && !c.rst) begin
      if (frame_start) begin
        if (track_ok) check_eq("lines_per_frame", 32'(lines), 32'(V_ACT));
        lines    = 0;
        track_ok = 1'b1;
      end
      if (line_start) lines++;
    end
  endtask

  initial begin
    checks = 0; errors = 0; m = 0;
    rstn = 1'b0; test_mode = 2'b00;
    video_on = 1'b0; horiz_sync = 1'b0; vert_sync = 1'b0;
    pixel_row = '0; pixel_column = '0; rgb_r = '0; rgb_g = '0; rgb_b = '0;
    for (int i = 0; i < 16; i++) hist[i] = blank_smp();
    h = 0; v = V_ACT; frame = 0;
    mode_m = 0; cnt_m = 0; lines = 0; track_ok = 1'b0;
    rst_at = 4 * FRAME_CYC + int'($urandom_range(100, 400));

    for (int k = 1; k <= TOTAL; k++) begin
      @(posedge clk);
      #1;
      m = k;
      rstn = !((k < 6) || (k >= rst_at && k < rst_at + 5));
      if ($urandom_range(0, 249) == 0) test_mode = 2'($urandom_range(0, 3));
      if (frame == 12 && v == V_ACT && h == 5) begin
        force dut.frame_cnt_q = 16'hFFFF;
        cnt_m = 16'hFFFF;
      end
      if (frame == 12 && v == V_ACT && h == 6) release dut.frame_cnt_q;
      drive_and_record();
      @(negedge clk);
      check_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_out_stage.md
VGA_OUT_STAGE -- requirements
Module: vga_out_stage

Interface
REQ-001 Parameter PIPE_DLY, default 2, pixel-pipeline latency of upstream rojobot_controller in clk cycles; legal range 1..8.
REQ-002 Parameter COLOR_W, default 4, bits per colour channel.
REQ-003 clk  input  1  pixel clock (75 MHz domain); the only clock.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 video_on  input  1  active-video flag from display timing generator.
REQ-006 horiz_sync  input  1  horizontal sync from timing generator, polarity passed through unchanged.
REQ-007 vert_sync  input  1  vertical sync from timing generator, polarity passed through unchanged.
REQ-008 pixel_row  input  12  current row from timing generator.
REQ-009 pixel_column  input  12  current column from timing generator.
REQ-010 rgb_r / rgb_g / rgb_b  input  COLOR_W each  pixel colour from rojobot_controller, valid PIPE_DLY cycles after the row/column it belongs to.
REQ-011 test_mode  input  2  00 pass-through, 01 colour bars, 10 grid, 11 solid white.
REQ-012 VGA_R / VGA_G / VGA_B  output  COLOR_W each  registered colour to the VGA connector.
REQ-013 VGA_HS / VGA_VS  output  1 each  registered syncs aligned to VGA_R/G/B.
REQ-014 frame_start  output  1  one-cycle pulse at first active pixel of each frame.
REQ-015 line_start  output  1  one-cycle pulse at first active pixel of each line.
REQ-016 frame_cnt  output  16  count of frame_start pulses since reset.

Function
REQ-017 video_on, horiz_sync, vert_sync, pixel_row, pixel_column SHALL each be delayed exactly PIPE_DLY cycles (d_* signals).
REQ-018 All outputs SHALL be registered; total latency from timing input to VGA_HS/VGA_VS = PIPE_DLY+1 cycles; rgb_* input to VGA_R/G/B = 1 cycle.
REQ-019 When d_video_on=0, VGA_R/G/B SHALL be 0 regardless of mode.
REQ-020 Mode 00: VGA_* = rgb_* when d_video_on=1.
REQ-021 Mode 01: eight vertical bars indexed by d_pixel_column[9:7]; bar i colour = {R=i[2], G=i[1], B=i[0]}, each bit expanded to all-ones/all-zeros of COLOR_W; columns >= 1024 use bar 7.
REQ-022 Mode 10: all-ones on all channels when d_pixel_column[4:0]==0 or d_pixel_row[4:0]==0, else 0.
REQ-023 Mode 11: all channels all-ones.
REQ-024 Active mode SHALL be a register loaded from test_mode only in the cycle frame_start is generated; test_mode changes mid-frame take effect at next frame.
REQ-025 line_start SHALL pulse when d_video_on rises (0 in previous cycle, 1 now); output aligned with first VGA pixel of the line.
REQ-026 frame_start SHALL pulse when line_start condition holds and d_pixel_row==0.
REQ-027 frame_cnt SHALL increment by 1 on each frame_start, wrapping 0xFFFF -> 0x0000.
REQ-028 The d_video_on edge detector SHALL treat its previous-value register as 0 after reset, so a reset released mid-line yields line_start at the next true rising edge only if video_on was low for at least one delayed cycle.

Reset
REQ-029 While rstn=0: VGA_R/G/B=0, VGA_HS=0, VGA_VS=0, frame_start=0, line_start=0, frame_cnt=0, all delay-line stages 0, active mode=00.
REQ-030 Reset assertion SHALL take effect asynchronously; deassertion is consumed synchronously; first valid outputs appear PIPE_DLY+1 cycles after release.

Structure
REQ-031 Package vga_out_pkg SHALL hold the test-mode enum (TM_PASS, TM_BARS, TM_GRID, TM_WHITE), default COLOR_W, and the 8-entry bar colour table.
REQ-032 One sub-module sig_delay_line (parameters WIDTH, DEPTH; clk, rstn, d, q) SHALL implement REQ-017, instantiated once on the concatenated timing bus.

Verification
REQ-033 Reset mid-frame, release, PIPE_DLY=2: all outputs 0 during reset; VGA_HS first follows horiz_sync 3 cycles after release.
REQ-034 Mode 00, rgb_r=4'hA presented 2 cycles after column 100 with video_on=1 -> VGA_R=4'hA one cycle later, aligned with VGA_HS delayed 3 cycles.
REQ-035 Mode 01, 1024x768 frame -> column 0..127 black, 128..255 blue (VGA_B=4'hF), 896..1023 white; blanking gives 0.
REQ-036 Switch test_mode 00->11 at row 300 -> output unchanged until next frame_start, then all channels 4'hF in active video.
REQ-037 Run 3 frames -> frame_start exactly once per frame at row 0 col 0, 768 line_start pulses per frame, frame_cnt 0->3.
REQ-038 Preload frame_cnt path to 0xFFFF (force or 65535 short frames) -> next frame_start yields frame_cnt=0x0000.
